// File: rtl/fsic_io_serdes_link_ctrl.sv
// Serdes link bring-up sequencer: TX settle, RX enable, pattern lock, link monitor
// and bounded retraining. Every output is a flop decoded from the next state.
module fsic_io_serdes_link_ctrl #(
  parameter int unsigned             pNUM_LANES = 4,
  parameter int unsigned             pCLK_RATIO = 4,
  parameter logic [pCLK_RATIO-1:0]   pTRAIN_PAT = 4'b1010,
  parameter int unsigned             pTX_SETTLE = 16,
  parameter int unsigned             pLOCK_CNT  = 8,
  parameter int unsigned             pTIMEOUT   = 1023,
  parameter int unsigned             pMAX_RETRY = 3
) (
  input  logic                             coreclk,
  input  logic                             axis_rst_n,
  input  logic                             link_en,
  input  logic [pNUM_LANES*pCLK_RATIO-1:0] rxdata,
  input  logic [pNUM_LANES-1:0]            rxdata_valid,
  output logic                             rxen,
  output logic                             txen,
  output logic                             tx_train,
  output logic                             link_up,
  output logic                             train_fail,
  output logic [pNUM_LANES-1:0]            lane_err,
  output logic [3:0]                       retry_cnt
);

  localparam int unsigned RETRY_HOLD = 3;
  localparam int unsigned SMAX = (pTX_SETTLE > RETRY_HOLD) ? pTX_SETTLE : RETRY_HOLD;
  localparam int unsigned SW   = $clog2(SMAX + 1);
  localparam int unsigned TW   = $clog2(pTIMEOUT + 1);
  localparam int unsigned MW   = $clog2(pLOCK_CNT + 1);

  typedef enum logic [2:0] {
    IDLE, TX_ON, RX_ON, WAIT_VALID, LOCK, LINK_UP, RETRY, FAIL
  } state_t;

  state_t                 state, state_n;
  logic [SW-1:0]          scnt, scnt_n;
  logic [TW-1:0]          tcnt, tcnt_n;
  logic [MW-1:0]          mcnt, mcnt_n;
  logic [pNUM_LANES-1:0]  lerr_n, lane_bad;
  logic [3:0]             rcnt_n;
  logic                   all_valid, go_retry, timeout;

  always_comb begin
    lane_bad = '0;
    for (int unsigned i = 0; i < pNUM_LANES; i++) begin
      lane_bad[i] = !rxdata_valid[i] ||
                    (rxdata[i*pCLK_RATIO +: pCLK_RATIO] != pTRAIN_PAT);
    end
  end

  assign all_valid = &rxdata_valid;
  assign timeout   = (tcnt == TW'(pTIMEOUT - 1));

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    tcnt_n   = tcnt;
    mcnt_n   = mcnt;
    lerr_n   = lane_err;
    rcnt_n   = retry_cnt;
    go_retry = 1'b0;
    unique case (state)
      IDLE: if (link_en) begin
        state_n = TX_ON;
        scnt_n  = '0;
        lerr_n  = '0;
      end
      TX_ON: begin
        if (scnt == SW'(pTX_SETTLE)) begin
          state_n = RX_ON;
          tcnt_n  = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      RX_ON: state_n = WAIT_VALID;
      WAIT_VALID: begin
        tcnt_n = tcnt + TW'(1);
        if (timeout) begin
          go_retry = 1'b1;
        end else if (all_valid) begin
          state_n = LOCK;
          mcnt_n  = '0;
        end
      end
      LOCK: begin
        tcnt_n = tcnt + TW'(1);
        if (timeout) begin
          go_retry = 1'b1;
        end else if (|lane_bad) begin
          mcnt_n = '0;
          lerr_n = lane_err | lane_bad;
        end else if (mcnt == MW'(pLOCK_CNT - 1)) begin
          state_n = LINK_UP;
        end else begin
          mcnt_n = mcnt + MW'(1);
        end
      end
      LINK_UP: if (!all_valid) go_retry = 1'b1;
      RETRY: begin
        if (scnt == SW'(RETRY_HOLD)) begin
          if (retry_cnt > 4'(pMAX_RETRY)) begin
            state_n = FAIL;
          end else begin
            state_n = RX_ON;
            tcnt_n  = '0;
          end
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      FAIL: state_n = FAIL;
      default: state_n = IDLE;
    endcase
    if (go_retry) begin
      state_n = RETRY;
      scnt_n  = '0;
      rcnt_n  = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    end
    // Disable overrides every transition above, including retry entry.
    if (!link_en) begin
      state_n = IDLE;
      scnt_n  = '0;
      tcnt_n  = '0;
      mcnt_n  = '0;
      lerr_n  = '0;
      rcnt_n  = '0;
    end
  end

  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state      <= IDLE;
      scnt       <= '0;
      tcnt       <= '0;
      mcnt       <= '0;
      lane_err   <= '0;
      retry_cnt  <= '0;
      rxen       <= 1'b0;
      txen       <= 1'b0;
      tx_train   <= 1'b0;
      link_up    <= 1'b0;
      train_fail <= 1'b0;
    end else begin
      state      <= state_n;
      scnt       <= scnt_n;
      tcnt       <= tcnt_n;
      mcnt       <= mcnt_n;
      lane_err   <= lerr_n;
      retry_cnt  <= rcnt_n;
      rxen       <= (state_n inside {RX_ON, WAIT_VALID, LOCK, LINK_UP});
      txen       <= (state_n inside {TX_ON, RX_ON, WAIT_VALID, LOCK, LINK_UP, RETRY});
      tx_train   <= (state_n inside {TX_ON, RX_ON, WAIT_VALID, LOCK, RETRY});
      link_up    <= (state_n == LINK_UP);
      train_fail <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_fsic_io_serdes_link_ctrl.sv
// Directed bench for fsic_io_serdes_link_ctrl; outputs sampled 1ns after posedge.
module tb_fsic_io_serdes_link_ctrl;

  logic        coreclk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        link_en = 1'b0;
  logic [15:0] rxdata = 16'hAAAA;
  logic [3:0]  rxdata_valid = 4'h0;
  logic        rxen, txen, tx_train, link_up, train_fail;
  logic [3:0]  lane_err;
  logic [3:0]  retry_cnt;
  logic [4:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  // outs = {rxen, txen, tx_train, link_up, train_fail}
  assign outs = {rxen, txen, tx_train, link_up, train_fail};

  always #5 coreclk = ~coreclk;

  fsic_io_serdes_link_ctrl #(
    .pNUM_LANES(4), .pCLK_RATIO(4), .pTRAIN_PAT(4'b1010), .pTX_SETTLE(16),
    .pLOCK_CNT(8), .pTIMEOUT(1023), .pMAX_RETRY(3)
  ) dut (
    .coreclk(coreclk), .axis_rst_n(axis_rst_n), .link_en(link_en),
    .rxdata(rxdata), .rxdata_valid(rxdata_valid), .rxen(rxen), .txen(txen),
    .tx_train(tx_train), .link_up(link_up), .train_fail(train_fail),
    .lane_err(lane_err), .retry_cnt(retry_cnt)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge coreclk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (outs !== 5'b00000 || lane_err !== 4'h0 || retry_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_vals: outs=%b lane_err=%h retry=%0d want 00000/0/0", outs, lane_err, retry_cnt);
    end
    repeat (2) @(posedge coreclk);
    #3 axis_rst_n = 1'b1;
    cyc(2);
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++;
      $display("FAIL idle_after_reset: outs=%b want 00000", outs);
    end
  endtask

  task automatic test_clean_bringup;
    rxdata = 16'hAAAA; rxdata_valid = 4'hF; link_en = 1'b1;
    cyc(1); // edge 1
    n_checks++;
    if (outs !== 5'b01100) begin
      n_fail++;
      $display("FAIL clean_txon: outs=%b want 01100", outs);
    end
    cyc(16); // edge 17
    n_checks++;
    if (outs !== 5'b01100) begin
      n_fail++;
      $display("FAIL clean_settle: outs=%b want 01100", outs);
    end
    cyc(1); // edge 18
    n_checks++;
    if (outs !== 5'b11100) begin
      n_fail++;
      $display("FAIL clean_rxen: outs=%b want 11100", outs);
    end
    cyc(9); // edge 27
    n_checks++;
    if (link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_early_up: link_up=%b want 0", link_up);
    end
    cyc(1); // edge 28
    n_checks++;
    if (outs !== 5'b11010 || lane_err !== 4'h0 || retry_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL clean_up: outs=%b lane_err=%h retry=%0d want 11010/0/0", outs, lane_err, retry_cnt);
    end
  endtask

  task automatic test_disable_idle;
    link_en = 1'b0;
    cyc(1);
    n_checks++;
    if (outs !== 5'b00000 || retry_cnt !== 4'h0 || lane_err !== 4'h0) begin
      n_fail++;
      $display("FAIL disable_up: outs=%b retry=%0d lane_err=%h want 00000/0/0", outs, retry_cnt, lane_err);
    end
    cyc(1);
  endtask

  task automatic test_lane_mismatch;
    rxdata = 16'hAAAA; rxdata_valid = 4'hF; link_en = 1'b1;
    cyc(24); // edge 24: fifth LOCK cycle begins
    rxdata = 16'hA0AA;
    cyc(1); // edge 25
    n_checks++;
    if (lane_err !== 4'b0100 || link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_err: lane_err=%b link_up=%b want 0100/0", lane_err, link_up);
    end
    rxdata = 16'hAAAA;
    cyc(7); // edge 32
    n_checks++;
    if (link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_restart: link_up=%b want 0", link_up);
    end
    cyc(1); // edge 33
    n_checks++;
    if (outs !== 5'b11010 || lane_err !== 4'b0100) begin
      n_fail++;
      $display("FAIL mismatch_up: outs=%b lane_err=%b want 11010/0100", outs, lane_err);
    end
  endtask

  task automatic test_link_drop;
    rxdata_valid = 4'hE;
    cyc(1); // edge k+1: RETRY
    rxdata_valid = 4'hF;
    n_checks++;
    if (outs !== 5'b01100 || retry_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL drop_retry: outs=%b retry=%0d want 01100/1", outs, retry_cnt);
    end
    cyc(3); // k+4
    n_checks++;
    if (rxen !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_rxen_hold: rxen=%b want 0", rxen);
    end
    cyc(1); // k+5: RX_ON
    n_checks++;
    if (outs !== 5'b11100) begin
      n_fail++;
      $display("FAIL drop_rxon: outs=%b want 11100", outs);
    end
    cyc(9); // k+14
    n_checks++;
    if (link_up !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_early_up: link_up=%b want 0", link_up);
    end
    cyc(1); // k+15
    n_checks++;
    if (outs !== 5'b11010 || retry_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL drop_relock: outs=%b retry=%0d want 11010/1", outs, retry_cnt);
    end
  endtask

  task automatic test_disable_lock;
    rxdata = 16'hAAAA; rxdata_valid = 4'hF; link_en = 1'b1;
    cyc(20); // edge 20: LOCK
    rxdata = 16'h0AAA;
    cyc(1);
    rxdata = 16'hAAAA;
    n_checks++;
    if (lane_err !== 4'b1000 || outs !== 5'b11100) begin
      n_fail++;
      $display("FAIL lock_err: lane_err=%b outs=%b want 1000/11100", lane_err, outs);
    end
    link_en = 1'b0;
    cyc(1);
    n_checks++;
    if (outs !== 5'b00000 || lane_err !== 4'h0 || retry_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL disable_lock: outs=%b lane_err=%h retry=%0d want 00000/0/0", outs, lane_err, retry_cnt);
    end
    cyc(1);
  endtask

  task automatic test_never_valid;
    rxdata_valid = 4'h0; link_en = 1'b1;
    cyc(1041); // edge 1041: last WAIT_VALID cycle
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rxen !== 1'b1 || retry_cnt !== 4'(k - 1)) begin
        n_fail++;
        $display("FAIL timeout_pre%0d: rxen=%b retry=%0d want 1/%0d", k, rxen, retry_cnt, k - 1);
      end
      cyc(1);
      n_checks++;
      if (outs !== 5'b01100 || retry_cnt !== 4'(k)) begin
        n_fail++;
        $display("FAIL timeout_retry%0d: outs=%b retry=%0d want 01100/%0d", k, outs, retry_cnt, k);
      end
      if (k < 4) cyc(1027);
    end
    cyc(3);
    n_checks++;
    if (outs !== 5'b01100) begin
      n_fail++;
      $display("FAIL fail_pre: outs=%b want 01100", outs);
    end
    cyc(1);
    n_checks++;
    if (outs !== 5'b00001 || retry_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL fail_state: outs=%b retry=%0d want 00001/4", outs, retry_cnt);
    end
    cyc(5);
    n_checks++;
    if (train_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_sticky: train_fail=%b want 1", train_fail);
    end
    link_en = 1'b0;
    cyc(1);
    n_checks++;
    if (outs !== 5'b00000 || retry_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL disable_fail: outs=%b retry=%0d want 00000/0", outs, retry_cnt);
    end
    cyc(1);
  endtask

  task automatic test_async_reset;
    rxdata_valid = 4'hF; link_en = 1'b1;
    cyc(5);
    n_checks++;
    if (outs !== 5'b01100) begin
      n_fail++;
      $display("FAIL pre_reset_txon: outs=%b want 01100", outs);
    end
    #2 axis_rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 5'b00000 || retry_cnt !== 4'h0 || lane_err !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: outs=%b retry=%0d lane_err=%h want 00000/0/0", outs, retry_cnt, lane_err);
    end
    link_en = 1'b0;
    cyc(1);
    axis_rst_n = 1'b1;
    cyc(1);
    link_en = 1'b1;
    cyc(1);
    n_checks++;
    if (outs !== 5'b01100) begin
      n_fail++;
      $display("FAIL restart_after_reset: outs=%b want 01100", outs);
    end
    link_en = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_disable_idle();
    test_lane_mismatch();
    test_link_drop();
    test_disable_idle();
    test_disable_lock();
    test_never_valid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsic_io_serdes_link_ctrl.md
Name: fsic_io_serdes_link_ctrl

Overview:
- Link-bring-up sequencer for the multi-lane IO serdes. Runs in the core clock domain.
- Drives the shared rxen/txen lane enables and requests a training pattern from the TX side.
- Qualifies the deserialized per-lane rxdata words against that pattern, then declares the link up.
- Monitors the live link and retrains with bounded retries; on exhaustion, reports a sticky failure.

Parameters:
pNUM_LANES, 4, number of serdes lanes controlled (1..16)
pCLK_RATIO, 4, bits per lane per coreclk word (matches the rx deserializer)
pTRAIN_PAT, 4'b1010, expected per-lane training word (pCLK_RATIO bits)
pTX_SETTLE, 16, coreclk cycles between txen and rxen assertion
pLOCK_CNT, 8, consecutive all-lane matches required for lock
pTIMEOUT, 1023, max cycles in WAIT_VALID+LOCK per attempt
pMAX_RETRY, 3, retries before FAIL

Ports:
coreclk  in  1  core clock; all logic is posedge
axis_rst_n  in  1  asynchronous active-low reset
link_en  in  1  software enable; low forces IDLE
rxdata  in  pNUM_LANES*pCLK_RATIO  deserialized words; lane i is bits [i*pCLK_RATIO +: pCLK_RATIO]
rxdata_valid  in  pNUM_LANES  per-lane valid from the rx deserializers
rxen  out  1  rx deserializer enable, all lanes
txen  out  1  tx serializer enable, all lanes
tx_train  out  1  TX sends pTRAIN_PAT while high
link_up  out  1  link trained, user data may flow
train_fail  out  1  retries exhausted; sticky until link_en low
lane_err  out  pNUM_LANES  sticky per-lane mismatch seen during the last LOCK attempt
retry_cnt  out  4  retries used in the current bring-up (saturates at 15)

Behaviour:
- Clock and reset: one clock, coreclk; reset is asynchronous and active-low on axis_rst_n. While in reset, all outputs are 0, state is IDLE, and counters are 0.
- All outputs are registered. An output change takes effect the cycle after the state transition.
- IDLE: all outputs 0. Move to TX_ON when link_en=1.
- TX_ON:
  - txen=1, tx_train=1. The counter counts pTX_SETTLE cycles, then move to RX_ON.
  - On entry, lane_err is cleared.
- RX_ON: rxen=1 for exactly 1 cycle of this state, then move to WAIT_VALID. The timeout counter is cleared on entry.
- WAIT_VALID: wait for rxdata_valid all-ones, then move to LOCK.
- LOCK:
  - Each cycle, all lanes valid and every lane word == pTRAIN_PAT increments match_cnt.
  - Any mismatch or invalid lane resets match_cnt to 0 and sets the lane_err bit of each offending lane.
  - match_cnt == pLOCK_CNT-1 with a matching cycle moves to LINK_UP.
- Timeout: the timeout counter increments in WAIT_VALID and LOCK. Reaching pTIMEOUT moves to RETRY; this takes priority over a lock in the same cycle.
- LINK_UP:
  - link_up=1, tx_train=0, txen=rxen=1.
  - Any rxdata_valid bit low for 1 cycle moves to RETRY. link_up drops the next cycle.
- RETRY:
  - rxen=0, tx_train=1, txen held 1. The state holds 4 cycles.
  - retry_cnt increments on entry (saturating).
  - If the incremented value > pMAX_RETRY, go to FAIL; else go to RX_ON.
- FAIL: train_fail=1, rxen=txen=tx_train=link_up=0. The state holds until link_en=0.
- link_en=0 in any state: go to IDLE next cycle and clear retry_cnt, train_fail and lane_err.
- link_en re-asserted while still in IDLE: normal restart.
- Asynchronous reset mid-sequence: immediate return to IDLE values. No partial-state resume.
- Counter widths are $clog2(param+1). No counter wraps; each is cleared on state entry.

Test Plan:
- Clean bring-up: link_en=1; after settle, valid=4'hF, all lanes 4'b1010. Require txen at cycle 1, rxen at cycle 18 (pTX_SETTLE=16), link_up 8 cycles after all-valid+pattern, tx_train=0 with link_up.
- Lane 2 mismatch: inject 4'b0000 on lane 2 at the 5th lock cycle. Require match_cnt restart, lane_err=4'b0100, link_up 8 clean cycles later.
- Never valid: rxdata_valid=0. Require RETRY at 1023 cycles, retry_cnt 1,2,3, then train_fail=1 and all enables 0 after the 4th timeout.
- Link drop: from LINK_UP, pulse rxdata_valid[0]=0 for 1 cycle. Require link_up=0 next cycle, rxen low 4 cycles, retry_cnt=1, relock to link_up=1.
- Disable and reset: link_en=0 in LOCK, then in FAIL. Require IDLE, all outputs 0 and retry_cnt=0 next cycle. Assert axis_rst_n=0 asynchronously mid-TX_ON: outputs 0 without a clock edge.
